// File: rtl/ir_key_ctrl.sv
// IR command controller: validates NEC frames, generates key and repeat events,
// and maintains the 6-digit BCD entry buffer that drives the display.
module ir_key_ctrl #(
  parameter logic [15:0] CUSTOM_CODE = 16'h00FF,
  parameter int          TIMEOUT_CYC = 6_000_000,
  parameter int          CNT_W       = 23
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_frame,
  input  logic        i_frame_vld,
  input  logic        i_repeat,
  output logic [7:0]  o_key,
  output logic        o_key_vld,
  output logic        o_key_rpt,
  output logic        o_held,
  output logic [23:0] o_digits,
  output logic [7:0]  o_err_cnt
);

  typedef enum logic [1:0] {IDLE, CHECK, HELD} state_e;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e      state_q, state_d;
  logic [31:0] frame_q, frame_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]  key_q, key_d;
  logic        key_vld_q, key_vld_d;
  logic        key_rpt_q, key_rpt_d;
  logic        held_q, held_d;
  logic [23:0] digits_q, digits_d;
  logic [7:0]  err_q, err_d;
  logic        ok;

  // Digit entry and CLEAR act only on a fresh press; BACK also steps on repeat.
  function automatic logic [23:0] buf_act(input logic [23:0] d, input logic [7:0] cmd,
                                          input logic rpt);
    buf_act = d;
    if (cmd <= 8'h09 && !rpt)       buf_act = {d[19:0], cmd[3:0]};
    else if (cmd == 8'h0A && !rpt)  buf_act = '0;
    else if (cmd == 8'h0B)          buf_act = {4'h0, d[23:4]};
  endfunction

  assign ok = (frame_q[31:16] == CUSTOM_CODE) && (frame_q[7:0] == ~frame_q[15:8]);

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    cnt_d     = cnt_q;
    key_d     = key_q;
    key_vld_d = 1'b0;
    key_rpt_d = 1'b0;
    held_d    = held_q;
    digits_d  = digits_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (i_frame_vld) begin
          frame_d = i_frame;
          cnt_d   = '0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (ok) begin
          key_d     = frame_q[15:8];
          key_vld_d = 1'b1;
          held_d    = 1'b1;
          digits_d  = buf_act(digits_q, frame_q[15:8], 1'b0);
          cnt_d     = '0;
          state_d   = HELD;
        end else begin
          err_d   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
          held_d  = 1'b0;
          state_d = IDLE;
        end
      end
      HELD: begin
        // A new frame outranks a coincident repeat; a repeat outranks timeout.
        if (i_frame_vld) begin
          frame_d = i_frame;
          cnt_d   = '0;
          state_d = CHECK;
        end else if (i_repeat) begin
          cnt_d     = '0;
          key_vld_d = 1'b1;
          key_rpt_d = 1'b1;
          digits_d  = buf_act(digits_q, key_q, 1'b1);
        end else if (cnt_q == TMO_LAST) begin
          held_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      cnt_q     <= '0;
      key_q     <= '0;
      key_vld_q <= 1'b0;
      key_rpt_q <= 1'b0;
      held_q    <= 1'b0;
      digits_q  <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      key_vld_q <= key_vld_d;
      key_rpt_q <= key_rpt_d;
      held_q    <= held_d;
      digits_q  <= digits_d;
      err_q     <= err_d;
    end
  end

  assign o_key     = key_q;
  assign o_key_vld = key_vld_q;
  assign o_key_rpt = key_rpt_q;
  assign o_held    = held_q;
  assign o_digits  = digits_q;
  assign o_err_cnt = err_q;

endmodule

// File: tb/tb_ir_key_ctrl.sv
// Directed bench for ir_key_ctrl: table of single frames plus hand sequences
// for repeat, timeout, saturation, collision and mid-check reset.
module tb_ir_key_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i_frame = '0;
  logic        i_frame_vld = 1'b0;
  logic        i_repeat = 1'b0;
  logic [7:0]  o_key;
  logic        o_key_vld;
  logic        o_key_rpt;
  logic        o_held;
  logic [23:0] o_digits;
  logic [7:0]  o_err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  ir_key_ctrl #(.CUSTOM_CODE(16'h00FF), .TIMEOUT_CYC(100), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .i_frame(i_frame), .i_frame_vld(i_frame_vld),
    .i_repeat(i_repeat), .o_key(o_key), .o_key_vld(o_key_vld), .o_key_rpt(o_key_rpt),
    .o_held(o_held), .o_digits(o_digits), .o_err_cnt(o_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] frame;
    logic        ok;
    logic [7:0]  key;
    logic [23:0] digits;
    logic [7:0]  err;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_frame_vld = 1'b0;
    i_repeat = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Leaves the bench at the negedge right after the check edge (N+1).
  task automatic send_frame(input logic [31:0] f);
    @(negedge clk);
    i_frame = f;
    i_frame_vld = 1'b1;
    @(negedge clk);
    i_frame_vld = 1'b0;
    @(negedge clk);
  endtask

  // Leaves the bench at the negedge right after the repeat edge.
  task automatic send_repeat();
    @(negedge clk);
    i_repeat = 1'b1;
    @(negedge clk);
    i_repeat = 1'b0;
  endtask

  initial begin
    int waited;
    int pulses;
    vecs[0]  = '{32'h00FF_05FA, 1'b1, 8'h05, 24'h000005, 8'd0};
    vecs[1]  = '{32'h00FF_01FE, 1'b1, 8'h01, 24'h000051, 8'd0};
    vecs[2]  = '{32'h00FF_02FD, 1'b1, 8'h02, 24'h000512, 8'd0};
    vecs[3]  = '{32'h00FF_03FC, 1'b1, 8'h03, 24'h005123, 8'd0};
    vecs[4]  = '{32'h00FF_04FB, 1'b1, 8'h04, 24'h051234, 8'd0};
    vecs[5]  = '{32'h00FF_05FA, 1'b1, 8'h05, 24'h512345, 8'd0};
    vecs[6]  = '{32'h00FF_06F9, 1'b1, 8'h06, 24'h123456, 8'd0};
    vecs[7]  = '{32'h00FF_07F8, 1'b1, 8'h07, 24'h234567, 8'd0};
    vecs[8]  = '{32'h00FF_0BF4, 1'b1, 8'h0B, 24'h023456, 8'd0};
    vecs[9]  = '{32'h00FF_0AF5, 1'b1, 8'h0A, 24'h000000, 8'd0};
    vecs[10] = '{32'h00FF_09F6, 1'b1, 8'h09, 24'h000009, 8'd0};
    vecs[11] = '{32'h00FF_05FB, 1'b0, 8'h09, 24'h000009, 8'd1};
    vecs[12] = '{32'h1234_05FA, 1'b0, 8'h09, 24'h000009, 8'd2};
    vecs[13] = '{32'h00FF_45BA, 1'b1, 8'h45, 24'h000009, 8'd2};
    vecs[14] = '{32'h00FF_0EF1, 1'b1, 8'h0E, 24'h000009, 8'd2};

    do_reset();
    chk("rst_key", o_key, 0);
    chk("rst_vld", o_key_vld, 0);
    chk("rst_rpt", o_key_rpt, 0);
    chk("rst_held", o_held, 0);
    chk("rst_digits", o_digits, 0);
    chk("rst_err", o_err_cnt, 0);

    for (int i = 0; i < NV; i++) begin
      send_frame(vecs[i].frame);
      chk($sformatf("v%0d_vld", i), o_key_vld, vecs[i].ok);
      chk($sformatf("v%0d_rpt", i), o_key_rpt, 0);
      chk($sformatf("v%0d_key", i), o_key, vecs[i].key);
      chk($sformatf("v%0d_digits", i), o_digits, vecs[i].digits);
      chk($sformatf("v%0d_err", i), o_err_cnt, vecs[i].err);
      chk($sformatf("v%0d_held", i), o_held, vecs[i].ok);
      @(negedge clk);
      chk($sformatf("v%0d_vld_off", i), o_key_vld, 0);
    end

    // Error counter saturation, no key events from bad frames.
    pulses = 0;
    for (int i = 0; i < 300; i++) begin
      send_frame(32'h00FF_05FB);
      if (o_key_vld) pulses++;
    end
    chk("err_sat", o_err_cnt, 8'd255);
    chk("err_no_pulse", pulses, 0);
    chk("err_digits", o_digits, 24'h000009);

    // Repeats on a digit key, then timeout 100 cycles after the last repeat.
    do_reset();
    send_frame(32'h00FF_03FC);
    chk("t4_digits", o_digits, 24'h000003);
    for (int r = 0; r < 3; r++) begin
      repeat (48) @(negedge clk);
      send_repeat();
      chk($sformatf("t4_rpt%0d_vld", r), o_key_vld, 1);
      chk($sformatf("t4_rpt%0d_rpt", r), o_key_rpt, 1);
      chk($sformatf("t4_rpt%0d_key", r), o_key, 8'h03);
      chk($sformatf("t4_rpt%0d_digits", r), o_digits, 24'h000003);
    end
    repeat (99) @(negedge clk);
    chk("t4_held_99", o_held, 1);
    @(negedge clk);
    chk("t4_held_100", o_held, 0);

    // BACK repeats, then a late repeat after timeout.
    do_reset();
    for (int d = 1; d <= 6; d++) begin
      logic [7:0] c;
      c = 8'(d);
      send_frame({16'h00FF, c, ~c});
    end
    chk("t5_digits", o_digits, 24'h123456);
    send_frame(32'h00FF_0BF4);
    chk("t5_back", o_digits, 24'h012345);
    send_repeat();
    chk("t5_rpt1_vld", o_key_rpt, 1);
    chk("t5_rpt1", o_digits, 24'h001234);
    send_repeat();
    chk("t5_rpt2", o_digits, 24'h000123);
    waited = 0;
    while (o_held && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("t5_timeout_bound", (waited < 200), 1);
    repeat (9) @(negedge clk);
    send_repeat();
    chk("t5_late_vld", o_key_vld, 0);
    chk("t5_late_held", o_held, 0);
    chk("t5_late_digits", o_digits, 24'h000123);

    // Frame and repeat together in HELD: only the new press.
    send_frame(32'h00FF_07F8);
    chk("t6_pre", o_digits, 24'h001237);
    @(negedge clk);
    i_frame = 32'h00FF_08F7;
    i_frame_vld = 1'b1;
    i_repeat = 1'b1;
    @(negedge clk);
    i_frame_vld = 1'b0;
    i_repeat = 1'b0;
    chk("t6_no_rpt_pulse", o_key_vld, 0);
    chk("t6_held_mid", o_held, 1);
    @(negedge clk);
    chk("t6_vld", o_key_vld, 1);
    chk("t6_rpt", o_key_rpt, 0);
    chk("t6_key", o_key, 8'h08);
    chk("t6_digits", o_digits, 24'h012378);

    // Reset during CHECK.
    @(negedge clk);
    i_frame = 32'h00FF_05FA;
    i_frame_vld = 1'b1;
    @(negedge clk);
    i_frame_vld = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_key", o_key, 0);
    chk("t6_rst_held", o_held, 0);
    chk("t6_rst_digits", o_digits, 0);
    @(negedge clk);
    chk("t6_rst_vld", o_key_vld, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_after_vld", o_key_vld, 0);
    chk("t6_after_digits", o_digits, 0);
    chk("t6_after_err", o_err_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
